// File: rtl/byte_unstriping.sv
// byte_unstriping: merges two 32-bit lanes back into one stream on clk_2f.
// The output order alternates lane0, lane1, lane0, ... and always starts on
// lane0. A FIFO per lane absorbs the skew between the two lanes.
//
// Optional feature (compile-time macro STALL_TIMEOUT_EN): a stall counter.
// When the selected lane stays empty for TIMEOUT cycles, the block sets the
// sticky lane_err flag, flushes both FIFOs and returns to IDLE. Without the
// macro the merger waits indefinitely and lane_err is tied to 0.
//
// Ports:
//   clk_2f      single clock, rising edge
//   reset_L     asynchronous active-low reset
//   lane0/1     lane words, qualified by valid_0/valid_1
//   data_out    merged word (registered), new when valid_out=1
//   active      merger running (state != IDLE)
//   overflow_0/1 sticky: a word on that lane was dropped because its FIFO was full
//   lane_err    sticky stall-timeout flag
module byte_unstriping #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] lane0,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] lane1,
  input  logic              valid_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              overflow_0,
  output logic              overflow_1,
  output logic              lane_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("byte_unstriping: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("byte_unstriping: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SEL0, SEL1} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [PTR_W-1:0]  wr0, rd0, wr1, rd1;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              pop0, pop1, stall, flush;
  logic              push0, push1, drop0, drop1;

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] stall_cnt;
`endif

  // Next-state and pop decisions, based on counts before the edge.
  always_comb begin
    state_nxt = state;
    pop0      = 1'b0;
    pop1      = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: if (cnt0 != '0) state_nxt = SEL0;
      SEL0: begin
        if (cnt0 != '0) begin
          pop0      = 1'b1;
          state_nxt = SEL1;
        end else begin
          stall = 1'b1;
        end
      end
      SEL1: begin
        if (cnt1 != '0) begin
          pop1      = 1'b1;
          state_nxt = SEL0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef STALL_TIMEOUT_EN
    flush = stall && (stall_cnt == TO_W'(TIMEOUT - 1));
`endif
    if (flush) state_nxt = IDLE;
  end

  // A full FIFO still accepts a word if it is popped on the same edge.
  assign push0 = valid_0 && ((cnt0 != FULL) || pop0) && !flush;
  assign push1 = valid_1 && ((cnt1 != FULL) || pop1) && !flush;
  assign drop0 = valid_0 && (cnt0 == FULL) && !pop0;
  assign drop1 = valid_1 && (cnt1 == FULL) && !pop1;

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk_2f) begin
    if (push0) mem0[wr0] <= lane0;
    if (push1) mem1[wr1] <= lane1;
  end

  // FIFO pointers and counts.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      wr0  <= '0;
      rd0  <= '0;
      cnt0 <= '0;
      wr1  <= '0;
      rd1  <= '0;
      cnt1 <= '0;
    end else if (flush) begin
      wr0  <= '0;
      rd0  <= '0;
      cnt0 <= '0;
      wr1  <= '0;
      rd1  <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) wr0 <= wr0 + PTR_W'(1);
      if (pop0)  rd0 <= rd0 + PTR_W'(1);
      if (push1) wr1 <= wr1 + PTR_W'(1);
      if (pop1)  rd1 <= rd1 + PTR_W'(1);
      cnt0 <= cnt0 + CNT_W'(push0) - CNT_W'(pop0);
      cnt1 <= cnt1 + CNT_W'(push1) - CNT_W'(pop1);
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      data_out   <= '0;
      valid_out  <= 1'b0;
      active     <= 1'b0;
      overflow_0 <= 1'b0;
      overflow_1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid_out  <= pop0 | pop1;
      active     <= (state_nxt != IDLE);
      overflow_0 <= overflow_0 | drop0;
      overflow_1 <= overflow_1 | drop1;
      if (pop0)      data_out <= mem0[rd0];
      else if (pop1) data_out <= mem1[rd1];
    end
  end

`ifdef STALL_TIMEOUT_EN
  // Stall counter: counts empty-turn cycles, clears on any pop or in IDLE.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      stall_cnt <= '0;
      lane_err  <= 1'b0;
    end else begin
      if (stall && !flush) stall_cnt <= stall_cnt + TO_W'(1);
      else                 stall_cnt <= '0;
      if (flush) lane_err <= 1'b1;
    end
  end
`else
  assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: a per-cycle vector table for the basic
// interleave, plus hand-written sequences for skew, overflow, IDLE buffering,
// asynchronous reset and (when compiled in) the stall timeout.
module tb_byte_unstriping;

  logic        clk_2f;
  logic        reset_L;
  logic [31:0] lane0, lane1;
  logic        valid_0, valid_1;
  logic [31:0] data_out;
  logic        valid_out, active, overflow_0, overflow_1, lane_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        ev;
    logic [31:0] ed;
    logic        ea;
  } vec_t;

  vec_t tbl[11];

  byte_unstriping #(.DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk_2f    (clk_2f),
    .reset_L   (reset_L),
    .lane0     (lane0),
    .valid_0   (valid_0),
    .lane1     (lane1),
    .valid_1   (valid_1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .overflow_0(overflow_0),
    .overflow_1(overflow_1),
    .lane_err  (lane_err)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock, then sample just after the edge.
  task automatic step(input logic v0, input logic [31:0] d0,
                      input logic v1, input logic [31:0] d1);
    valid_0 = v0;
    lane0   = d0;
    valid_1 = v1;
    lane1   = d1;
    @(posedge clk_2f);
    #1;
    if (valid_out) got.push_back(data_out);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    lane0   = 32'h0;
    lane1   = 32'h0;
    reset_L = 1'b0;
    @(posedge clk_2f);
    #1;
    reset_L = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_stream(input string name);
    check($sformatf("%s_count", name), 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
  endtask

  initial begin
    reset_L = 1'b1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    lane0   = 32'h0;
    lane1   = 32'h0;

    // Async reset with no clock edge in between.
    #2 reset_L = 1'b0;
    #1;
    check("rst_valid_out", 32'(valid_out), 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_overflow_0", 32'(overflow_0), 32'h0);
    check("rst_overflow_1", 32'(overflow_1), 32'h0);
    check("rst_lane_err", 32'(lane_err), 32'h0);
    @(posedge clk_2f);
    #1 reset_L = 1'b1;

    // Both lanes together for four cycles: A0,B0,A1,B1,... starting two edges in.
    tbl[0]  = '{1'b1, 32'hA000_0000, 1'b1, 32'hB000_0000, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 32'hA000_0001, 1'b1, 32'hB000_0001, 1'b0, 32'h0,         1'b1};
    tbl[2]  = '{1'b1, 32'hA000_0002, 1'b1, 32'hB000_0002, 1'b1, 32'hA000_0000, 1'b1};
    tbl[3]  = '{1'b1, 32'hA000_0003, 1'b1, 32'hB000_0003, 1'b1, 32'hB000_0000, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hA000_0001, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hB000_0001, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hA000_0002, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hB000_0002, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hA000_0003, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hB000_0003, 1'b1};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hB000_0003, 1'b1};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
      check($sformatf("tbl%0d_valid_out", i), 32'(valid_out), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_data_out", i), data_out, tbl[i].ed);
      check($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].ea));
    end
    check("tbl_overflow_0", 32'(overflow_0), 32'h0);
    check("tbl_overflow_1", 32'(overflow_1), 32'h0);

    // Lane1 three cycles behind lane0: order unchanged, nothing dropped.
    do_reset();
    for (int c = 0; c < 8; c++)
      step(c < 4, 32'hA000_0000 + 32'(c), (c >= 3 && c < 7), 32'hB000_0000 + 32'(c - 3));
    drain(6);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'hA000_0000 + 32'(i));
      exp_q.push_back(32'hB000_0000 + 32'(i));
    end
    check_stream("skew");
    check("skew_overflow_0", 32'(overflow_0), 32'h0);
    check("skew_overflow_1", 32'(overflow_1), 32'h0);

    // Overflow: merger parked in SEL1 while lane0 pushes six words.
    do_reset();
    step(1'b1, 32'h5555_0000, 1'b0, 32'h0);
    drain(2);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 32'h0);
      if (i == 3) check("ovf_after_4th", 32'(overflow_0), 32'h0);
      if (i == 4) check("ovf_after_5th", 32'(overflow_0), 32'h1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 32'hD000_0000 + 32'(i));
    drain(10);
    exp_q.push_back(32'h5555_0000);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'hD000_0000 + 32'(i));
      exp_q.push_back(32'hC000_0000 + 32'(i));
    end
    check_stream("ovf");
    check("ovf_sticky_0", 32'(overflow_0), 32'h1);
    check("ovf_overflow_1", 32'(overflow_1), 32'h0);
`ifndef STALL_TIMEOUT_EN
    check("ovf_lane_err_tied", 32'(lane_err), 32'h0);
`endif

    // Lane1-only traffic is buffered in IDLE; the stream still starts on lane0.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 32'h1111_2222);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0);
      check($sformatf("idle%0d_valid_out", i), 32'(valid_out), 32'h0);
      check($sformatf("idle%0d_active", i), 32'(active), 32'h0);
    end
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    drain(4);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h1111_2222);
    check_stream("lane1_first");

    // Asynchronous reset mid-stream; stale words must not reappear.
    do_reset();
    for (int i = 0; i < 4; i++) step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
    #3 reset_L = 1'b0;
    #1;
    check("amid_valid_out", 32'(valid_out), 32'h0);
    check("amid_data_out", data_out, 32'h0);
    check("amid_active", 32'(active), 32'h0);
    @(posedge clk_2f);
    #1 reset_L = 1'b1;
    got.delete();
    drain(6);
    check("amid_no_stale", 32'(got.size()), 32'h0);
    check("amid_idle_active", 32'(active), 32'h0);
    step(1'b1, 32'hE000_0000, 1'b1, 32'hE000_0001);
    drain(4);
    exp_q.push_back(32'hE000_0000);
    exp_q.push_back(32'hE000_0001);
    check_stream("amid_restart");

`ifdef STALL_TIMEOUT_EN
    // Stall timeout: one lane0 word, lane1 silent for eight SEL1 cycles.
    do_reset();
    step(1'b1, 32'h7000_0000, 1'b0, 32'h0);
    drain(2);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0);
      check($sformatf("to_wait%0d_lane_err", i), 32'(lane_err), 32'h0);
    end
    step(1'b0, 32'h0, 1'b0, 32'h0);
    check("to_lane_err", 32'(lane_err), 32'h1);
    check("to_active", 32'(active), 32'h0);
    check("to_valid_out", 32'(valid_out), 32'h0);
    step(1'b1, 32'h7000_0001, 1'b0, 32'h0);
    drain(3);
    exp_q.push_back(32'h7000_0000);
    exp_q.push_back(32'h7000_0001);
    check_stream("to_restart");
    check("to_lane_err_sticky", 32'(lane_err), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/byte_unstriping.md
Name: byte_unstriping

Overview:
- Receive-side counterpart of the TX byte striper.
- Takes 32-bit words arriving on two lanes (lane0, lane1), each with its own valid, and merges them back into one 32-bit stream on clk_2f.
- Restores the original order: lane0 word, then lane1 word, alternating.
- Per-lane FIFOs absorb inter-lane skew. Sits between the per-lane deserializers and the RX output stage.

Parameters:
- DATA_W, 32, width of every lane word and the output word.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- TIMEOUT, 8, stall-cycle limit; only used when STALL_TIMEOUT_EN is defined.

Ports:
- clk_2f  in  1  single clock; all logic on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- lane0  in  DATA_W  lane 0 word.
- valid_0  in  1  lane0 holds a word this cycle.
- lane1  in  DATA_W  lane 1 word.
- valid_1  in  1  lane1 holds a word this cycle.
- data_out  out  DATA_W  merged word, registered.
- valid_out  out  1  data_out is a new word this cycle.
- active  out  1  merger is running (state != IDLE).
- overflow_0  out  1  sticky: a lane0 word was dropped because its FIFO was full.
- overflow_1  out  1  sticky: same for lane1.
- lane_err  out  1  sticky stall-timeout flag; tied 0 without STALL_TIMEOUT_EN.

Behaviour:
- Reset (reset_L low, asynchronous):
  - data_out=0, valid_out=0, active=0, overflow_0=0, overflow_1=0, lane_err=0.
  - Both FIFOs empty; state=IDLE.
  - Reset mid-operation discards all buffered words.
- Lane FIFOs (one per lane, DEPTH entries, wrapping read/write pointers plus a count):
  - Each FIFO is written on every edge where its valid_x=1.
  - Write accepted if count<DEPTH, or if a pop of the same FIFO occurs on the same edge.
  - Otherwise the word is dropped and overflow_x is set; it stays set until reset.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SEL0, SEL1.
  - IDLE: valid_out=0. Go to SEL0 when FIFO0 is non-empty (count seen after the edge). No pop in IDLE, so the stream always starts on lane0. Lane1 words arriving in IDLE are buffered, not discarded.
  - SEL0, FIFO0 non-empty: pop, data_out<=head, valid_out<=1, next=SEL1.
  - SEL0, FIFO0 empty: valid_out<=0, stay in SEL0.
  - SEL1: mirror of SEL0 using FIFO1, next=SEL0.
  - There is no automatic return to IDLE except via reset or the optional timeout.
- data_out holds its last value whenever valid_out=0.
- active=1 in SEL0 and SEL1.
- Latency:
  - Word written to FIFO0 at edge N while in IDLE: appears on data_out at edge N+2.
  - Word whose FIFO is non-empty at the start of its turn: data_out valid at the next edge (1 cycle).
- Throughput: one word per clk_2f cycle when both lanes keep up. Steady state with both valids high alternates lane0, lane1, lane0, ...
- Simultaneous valid_0 and valid_1 are both accepted; order is determined only by the SEL alternation.
- Lane skew: if lane1 arrives up to DEPTH words after lane0, no data is lost. Lane0 keeps filling while the FSM waits in SEL1.

Optional Feature:
- Macro: STALL_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle spent in SEL0/SEL1 with the selected FIFO empty, and clears on any pop.
  - When the counter reaches TIMEOUT: set lane_err (sticky), flush both FIFOs, go to IDLE, valid_out=0.
  - Words written on that same edge are discarded by the flush.
- Not defined: no counter; the FSM waits indefinitely; lane_err is constant 0.

Test Plan:
- Reset, then valid_0=valid_1=1 for 4 cycles with lane0=A0,A1,A2,A3 and lane1=B0..B3 -> valid_out sequence A0,B0,A1,B1,A2,B2,A3,B3. First word appears 2 cycles after the first write edge, with no gaps afterwards.
- Lane1 delayed 3 cycles relative to lane0 (DEPTH=4), same data -> identical output order, overflow_0=overflow_1=0, valid_out low only during the wait gaps.
- Lane0 pushed 6 words while lane1 stays idle (FSM stalled in SEL1) -> FIFO0 keeps 4 words, overflow_0=1 after the 5th write and stays 1; the dropped words never appear on data_out.
- Only lane1 words sent after reset -> valid_out stays 0, active=0; first later lane0 word 0xDEAD_BEEF is output first, followed by the buffered lane1 word.
- reset_L asserted asynchronously mid-stream -> all outputs 0 immediately with no clock edge; after release, stale buffered words are never output.
- With STALL_TIMEOUT_EN and TIMEOUT=8: one lane0 word, lane1 silent -> after 8 stall cycles in SEL1, lane_err=1, active=0. A new lane0 word restarts the merge, and lane_err remains 1.
